// File: rtl/writeback_unit_pkg.sv
// Shared RV32I writeback definitions: datapath width, load funct3 encodings and FSM states.
// The optional misaligned-load trap is selected by WB_MISALIGN_TRAP_EN.
package writeback_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_WRITE = 2'd2
    } wb_state_e;

    // Byte loads are never misaligned; reserved encodings count as word loads.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            bad = lane[0];
        end else if (funct3[1:0] != 2'b00) begin
            bad = (lane != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Execute-stage handshake, data-memory read port and register-file write port of the writeback unit.
// load_fault is only present when WB_MISALIGN_TRAP_EN is defined.
interface writeback_unit_if
    import writeback_unit_pkg::*;
();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_result;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic            in_wb_en;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            write_enable;
`ifdef WB_MISALIGN_TRAP_EN
    logic            load_fault;

    modport master (
        output in_valid, in_rd, in_result, in_is_load, in_funct3, in_wb_en, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr, write_reg, write_data, write_enable, load_fault
    );
    modport slave (
        input  in_valid, in_rd, in_result, in_is_load, in_funct3, in_wb_en, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr, write_reg, write_data, write_enable, load_fault
    );
`else
    modport master (
        output in_valid, in_rd, in_result, in_is_load, in_funct3, in_wb_en, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr, write_reg, write_data, write_enable
    );
    modport slave (
        input  in_valid, in_rd, in_result, in_is_load, in_funct3, in_wb_en, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr, write_reg, write_data, write_enable
    );
`endif
endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational load alignment: picks the byte/halfword lane from the read word and extends it.
module load_align
    import writeback_unit_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: accepts one retiring instruction, performs load reads, pulses the regfile write.
// Define WB_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW on load_fault instead of executing them.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input logic             clock,
    input logic             reset,
    writeback_unit_if.slave bus
);
    wb_state_e       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lane_q, lane_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            write_enable_q, write_enable_d;
    logic [4:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [XLEN-1:0] aligned_data;
`ifdef WB_MISALIGN_TRAP_EN
    logic            load_fault_q, load_fault_d;
`endif

    load_align u_load_align (
        .rdata  (bus.mem_rdata),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .data   (aligned_data)
    );

    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        funct3_d       = funct3_q;
        lane_d         = lane_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        // write_reg/write_data default to 0: the regfile forwards on index match alone.
        write_enable_d = 1'b0;
        write_reg_d    = '0;
        write_data_d   = '0;
`ifdef WB_MISALIGN_TRAP_EN
        load_fault_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_is_load) begin
                        rd_d     = bus.in_rd;
                        funct3_d = bus.in_funct3;
                        lane_d   = bus.in_result[1:0];
`ifdef WB_MISALIGN_TRAP_EN
                        if (load_misaligned(bus.in_funct3, bus.in_result[1:0])) begin
                            load_fault_d = 1'b1;
                        end else
`endif
                        begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = {bus.in_result[XLEN-1:2], 2'b00};
                            state_d    = ST_MEM;
                        end
                    end else if (bus.in_wb_en) begin
                        state_d = ST_WRITE;
                        if (bus.in_rd != 5'd0) begin
                            write_enable_d = 1'b1;
                            write_reg_d    = bus.in_rd;
                            write_data_d   = bus.in_result;
                        end
                    end
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WRITE;
                    if (rd_q != 5'd0) begin
                        write_enable_d = 1'b1;
                        write_reg_d    = rd_q;
                        write_data_d   = aligned_data;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            load_fault_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
`ifdef WB_MISALIGN_TRAP_EN
            load_fault_q   <= load_fault_d;
`endif
        end
    end

    // Captured instruction fields carry no reset; they are only read in MEM.
    always_ff @(posedge clock) begin
        rd_q     <= rd_d;
        funct3_q <= funct3_d;
        lane_q   <= lane_d;
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.write_enable = write_enable_q;
    assign bus.write_reg    = write_reg_q;
    assign bus.write_data   = write_data_q;
`ifdef WB_MISALIGN_TRAP_EN
    assign bus.load_fault   = load_fault_q;
`endif
endmodule
